// File: rtl/typepkg.sv
// Shared 6502 decode types: mnemonic and addressing-mode enums, the length rule,
// and the packed ROM entry used by the instruction decoder.
`timescale 1ns/1ps
package typepkg;

  typedef enum logic [5:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
    CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
    JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
    RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
  } Opcode;

  typedef enum logic [3:0] {
    Imp, Acc, Imm, Zp, ZpX, ZpY, Abs, AbsX, AbsY, Ind, IndX, IndY, Rel
  } Addressing;

  localparam logic [7:0] OP_NOP = 8'hEA;

  typedef struct packed {
    Opcode     op;
    Addressing mode;
    logic      official;
  } dec_t;

  function automatic logic [1:0] ins_length(Addressing m);
    case (m)
      Imp, Acc:             return 2'd1;
      Abs, AbsX, AbsY, Ind: return 2'd3;
      default:              return 2'd2;
    endcase
  endfunction

  function automatic dec_t ent(Opcode o, Addressing m);
    dec_t d;
    d.op       = o;
    d.mode     = m;
    d.official = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/ins_reg_decode_rom.sv
// Combinational 256-entry opcode table for the official NMOS 6502 set.
// Unofficial opcodes decode as NOP/Imp; INS_ILLEGAL_TRAP_EN also flags them as illegal.
`timescale 1ns/1ps
module ins_decode_rom
  import typepkg::*;
(
  input  logic [7:0] ir,
  output Opcode      opcode,
  output Addressing  mode,
  output logic       illegal
);

`ifdef INS_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  dec_t e;

  always_comb begin
    e.op       = NOP;
    e.mode     = Imp;
    e.official = 1'b0;
    case (ir)
      8'h00: e = ent(BRK, Imp);  8'h01: e = ent(ORA, IndX); 8'h05: e = ent(ORA, Zp);   8'h06: e = ent(ASL, Zp);
      8'h08: e = ent(PHP, Imp);  8'h09: e = ent(ORA, Imm);  8'h0A: e = ent(ASL, Acc);  8'h0D: e = ent(ORA, Abs);
      8'h0E: e = ent(ASL, Abs);
      8'h10: e = ent(BPL, Rel);  8'h11: e = ent(ORA, IndY); 8'h15: e = ent(ORA, ZpX);  8'h16: e = ent(ASL, ZpX);
      8'h18: e = ent(CLC, Imp);  8'h19: e = ent(ORA, AbsY); 8'h1D: e = ent(ORA, AbsX); 8'h1E: e = ent(ASL, AbsX);
      8'h20: e = ent(JSR, Abs);  8'h21: e = ent(AND, IndX); 8'h24: e = ent(BIT, Zp);   8'h25: e = ent(AND, Zp);
      8'h26: e = ent(ROL, Zp);   8'h28: e = ent(PLP, Imp);  8'h29: e = ent(AND, Imm);  8'h2A: e = ent(ROL, Acc);
      8'h2C: e = ent(BIT, Abs);  8'h2D: e = ent(AND, Abs);  8'h2E: e = ent(ROL, Abs);
      8'h30: e = ent(BMI, Rel);  8'h31: e = ent(AND, IndY); 8'h35: e = ent(AND, ZpX);  8'h36: e = ent(ROL, ZpX);
      8'h38: e = ent(SEC, Imp);  8'h39: e = ent(AND, AbsY); 8'h3D: e = ent(AND, AbsX); 8'h3E: e = ent(ROL, AbsX);
      8'h40: e = ent(RTI, Imp);  8'h41: e = ent(EOR, IndX); 8'h45: e = ent(EOR, Zp);   8'h46: e = ent(LSR, Zp);
      8'h48: e = ent(PHA, Imp);  8'h49: e = ent(EOR, Imm);  8'h4A: e = ent(LSR, Acc);  8'h4C: e = ent(JMP, Abs);
      8'h4D: e = ent(EOR, Abs);  8'h4E: e = ent(LSR, Abs);
      8'h50: e = ent(BVC, Rel);  8'h51: e = ent(EOR, IndY); 8'h55: e = ent(EOR, ZpX);  8'h56: e = ent(LSR, ZpX);
      8'h58: e = ent(CLI, Imp);  8'h59: e = ent(EOR, AbsY); 8'h5D: e = ent(EOR, AbsX); 8'h5E: e = ent(LSR, AbsX);
      8'h60: e = ent(RTS, Imp);  8'h61: e = ent(ADC, IndX); 8'h65: e = ent(ADC, Zp);   8'h66: e = ent(ROR, Zp);
      8'h68: e = ent(PLA, Imp);  8'h69: e = ent(ADC, Imm);  8'h6A: e = ent(ROR, Acc);  8'h6C: e = ent(JMP, Ind);
      8'h6D: e = ent(ADC, Abs);  8'h6E: e = ent(ROR, Abs);
      8'h70: e = ent(BVS, Rel);  8'h71: e = ent(ADC, IndY); 8'h75: e = ent(ADC, ZpX);  8'h76: e = ent(ROR, ZpX);
      8'h78: e = ent(SEI, Imp);  8'h79: e = ent(ADC, AbsY); 8'h7D: e = ent(ADC, AbsX); 8'h7E: e = ent(ROR, AbsX);
      8'h81: e = ent(STA, IndX); 8'h84: e = ent(STY, Zp);   8'h85: e = ent(STA, Zp);   8'h86: e = ent(STX, Zp);
      8'h88: e = ent(DEY, Imp);  8'h8A: e = ent(TXA, Imp);  8'h8C: e = ent(STY, Abs);  8'h8D: e = ent(STA, Abs);
      8'h8E: e = ent(STX, Abs);
      8'h90: e = ent(BCC, Rel);  8'h91: e = ent(STA, IndY); 8'h94: e = ent(STY, ZpX);  8'h95: e = ent(STA, ZpX);
      8'h96: e = ent(STX, ZpY);  8'h98: e = ent(TYA, Imp);  8'h99: e = ent(STA, AbsY); 8'h9A: e = ent(TXS, Imp);
      8'h9D: e = ent(STA, AbsX);
      8'hA0: e = ent(LDY, Imm);  8'hA1: e = ent(LDA, IndX); 8'hA2: e = ent(LDX, Imm);  8'hA4: e = ent(LDY, Zp);
      8'hA5: e = ent(LDA, Zp);   8'hA6: e = ent(LDX, Zp);   8'hA8: e = ent(TAY, Imp);  8'hA9: e = ent(LDA, Imm);
      8'hAA: e = ent(TAX, Imp);  8'hAC: e = ent(LDY, Abs);  8'hAD: e = ent(LDA, Abs);  8'hAE: e = ent(LDX, Abs);
      8'hB0: e = ent(BCS, Rel);  8'hB1: e = ent(LDA, IndY); 8'hB4: e = ent(LDY, ZpX);  8'hB5: e = ent(LDA, ZpX);
      8'hB6: e = ent(LDX, ZpY);  8'hB8: e = ent(CLV, Imp);  8'hB9: e = ent(LDA, AbsY); 8'hBA: e = ent(TSX, Imp);
      8'hBC: e = ent(LDY, AbsX); 8'hBD: e = ent(LDA, AbsX); 8'hBE: e = ent(LDX, AbsY);
      8'hC0: e = ent(CPY, Imm);  8'hC1: e = ent(CMP, IndX); 8'hC4: e = ent(CPY, Zp);   8'hC5: e = ent(CMP, Zp);
      8'hC6: e = ent(DEC, Zp);   8'hC8: e = ent(INY, Imp);  8'hC9: e = ent(CMP, Imm);  8'hCA: e = ent(DEX, Imp);
      8'hCC: e = ent(CPY, Abs);  8'hCD: e = ent(CMP, Abs);  8'hCE: e = ent(DEC, Abs);
      8'hD0: e = ent(BNE, Rel);  8'hD1: e = ent(CMP, IndY); 8'hD5: e = ent(CMP, ZpX);  8'hD6: e = ent(DEC, ZpX);
      8'hD8: e = ent(CLD, Imp);  8'hD9: e = ent(CMP, AbsY); 8'hDD: e = ent(CMP, AbsX); 8'hDE: e = ent(DEC, AbsX);
      8'hE0: e = ent(CPX, Imm);  8'hE1: e = ent(SBC, IndX); 8'hE4: e = ent(CPX, Zp);   8'hE5: e = ent(SBC, Zp);
      8'hE6: e = ent(INC, Zp);   8'hE8: e = ent(INX, Imp);  8'hE9: e = ent(SBC, Imm);  8'hEA: e = ent(NOP, Imp);
      8'hEC: e = ent(CPX, Abs);  8'hED: e = ent(SBC, Abs);  8'hEE: e = ent(INC, Abs);
      8'hF0: e = ent(BEQ, Rel);  8'hF1: e = ent(SBC, IndY); 8'hF5: e = ent(SBC, ZpX);  8'hF6: e = ent(INC, ZpX);
      8'hF8: e = ent(SED, Imp);  8'hF9: e = ent(SBC, AbsY); 8'hFD: e = ent(SBC, AbsX); 8'hFE: e = ent(INC, AbsX);
      default: ;
    endcase
  end

  assign opcode  = e.op;
  assign mode    = e.mode;
  assign illegal = TRAP_EN & ~e.official;

endmodule

// File: rtl/ins_reg_decode.sv
// Instruction register plus two-byte operand capture feeding the sequencer.
// Build option INS_ILLEGAL_TRAP_EN (in ins_decode_rom) raises illegal for unofficial opcodes.
`timescale 1ns/1ps
module ins_reg_decode
  import typepkg::*;
#(
  parameter logic [7:0] RESET_IR = OP_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        ins_we,
  input  logic        opr_we,
  output Opcode       opcode,
  output Addressing   mode,
  output logic [1:0]  ins_len,
  output logic [15:0] operand,
  output logic [1:0]  opr_cnt,
  output logic        opr_done,
  output logic        illegal
);

  logic [7:0] ir_reg;
  logic [1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg  <= RESET_IR;
      cnt_reg <= 2'd0;
    end else if (ins_we) begin
      ir_reg  <= data;
      cnt_reg <= 2'd0;
    end else if (opr_we && cnt_reg != 2'd2) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  // Byte lane gi is written by the opr_we that arrives while gi bytes are held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opr_byte
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (reset || ins_we)
          byte_reg <= 8'h00;
        else if (opr_we && cnt_reg == 2'(gi))
          byte_reg <= data;
      end
      assign operand[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  ins_decode_rom u_rom (
    .ir      (ir_reg),
    .opcode  (opcode),
    .mode    (mode),
    .illegal (illegal)
  );

  assign ins_len  = ins_length(mode);
  assign opr_cnt  = cnt_reg;
  assign opr_done = (cnt_reg == ins_len - 2'd1);

endmodule
